// File: rtl/axi4_pkg.sv
// Shared types for the AXI4 slave read path: burst encodings, RRESP codes
// and the read-data engine state machine.
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_DATA
  } rd_state_t;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat byte address for FIXED/INCR/WRAP bursts.
// Zero latency; reserved burst type holds the address.
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  burst_t                burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] total;
  logic [ADDR_WIDTH-1:0] lower;
  logic [ADDR_WIDTH-1:0] incr;

  always_comb begin
    bytes = ONE << size;
    // total = bytes * (len + 1), formed as a shift since bytes is a power of two
    total = ({{(ADDR_WIDTH-8){1'b0}}, len} + ONE) << size;
    lower = addr & ~(total - ONE);
    incr  = addr + bytes;
    case (burst)
      BURST_INCR: next_addr = incr;
      BURST_WRAP: next_addr = (incr == lower + total) ? lower : incr;
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_read_data.sv
// AXI4 slave R-channel engine: pulse-to-RVALID 3 cycles, one beat per 3 cycles; beats held under RREADY low,
// one command may be queued while busy, further pulses dropped (cmd_overflow). Range check under AXI4_RD_ADDR_CHECK_EN.
module axi4_slave_read_data
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ar_transfer_occurred,
  input  logic [ADDR_WIDTH-1:0] latched_araddr,
  input  logic [ID_WIDTH-1:0]   latched_arid,
  input  logic [7:0]            latched_arlen,
  input  logic [2:0]            latched_arsize,
  input  logic [1:0]            latched_arburst,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rd_busy,
  output logic                  cmd_overflow
);

  localparam int OFF = $clog2(DATA_WIDTH / 8);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [ID_WIDTH-1:0]   id;
    logic [7:0]            len;
    logic [2:0]            size;
    burst_t                burst;
  } cmd_t;

  rd_state_t             state, state_nxt;
  cmd_t                  in_cmd, act, pend;
  logic                  pend_vld;
  logic [7:0]            beat_cnt;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  hs, last_beat, last_hs;
  logic                  load_act_new, load_act_pend, load_pend, drop;
  logic                  slv_err, dec_err;
  logic [1:0]            beat_resp;

  assign in_cmd = '{addr:  latched_araddr,
                    id:    latched_arid,
                    len:   latched_arlen,
                    size:  latched_arsize,
                    burst: burst_t'(latched_arburst)};

  assign hs        = (state == ST_DATA) && rvalid && rready;
  assign last_beat = (beat_cnt == act.len);
  assign last_hs   = hs && last_beat;

  // A pulse on the closing handshake goes straight to active only if nothing is queued ahead of it
  assign load_act_new  = ar_transfer_occurred && ((state == ST_IDLE) || (last_hs && !pend_vld));
  assign load_act_pend = last_hs && pend_vld;
  assign load_pend     = ar_transfer_occurred && !load_act_new && !pend_vld;
  assign drop          = ar_transfer_occurred && !load_act_new && pend_vld;

  assign word_addr = act.addr >> OFF;

  assign slv_err = (act.burst == BURST_RSVD) ||
                   ((act.burst == BURST_WRAP) && (act.len != 8'd1) && (act.len != 8'd3) &&
                    (act.len != 8'd7) && (act.len != 8'd15)) ||
                   (act.size > 3'(OFF));

`ifdef AXI4_RD_ADDR_CHECK_EN
  assign dec_err = (word_addr >= ADDR_WIDTH'(MEM_DEPTH));
`else
  assign dec_err = 1'b0;
`endif

  assign beat_resp = slv_err ? RESP_SLVERR : (dec_err ? RESP_DECERR : RESP_OKAY);

  axi4_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .addr      (act.addr),
    .size      (act.size),
    .len       (act.len),
    .burst     (act.burst),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    case (state)
      ST_IDLE: begin
        if (ar_transfer_occurred) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd_en   = (beat_resp == RESP_OKAY);
        mem_rd_addr = word_addr;
        state_nxt   = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (hs) begin
          if (!last_beat || pend_vld || load_act_new) state_nxt = ST_FETCH;
          else                                        state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act          <= '0;
      pend         <= '0;
      pend_vld     <= 1'b0;
      beat_cnt     <= 8'd0;
      cmd_overflow <= 1'b0;
      rvalid       <= 1'b0;
      rdata        <= '0;
      rresp        <= RESP_OKAY;
    end else begin
      if (load_act_new) begin
        act      <= in_cmd;
        beat_cnt <= 8'd0;
      end else if (load_act_pend) begin
        act      <= pend;
        beat_cnt <= 8'd0;
      end else if (hs) begin
        act.addr <= next_addr;
        beat_cnt <= beat_cnt + 8'd1;
      end

      if (load_pend)          pend <= in_cmd;
      if (load_act_pend)      pend_vld <= 1'b0;
      else if (load_pend)     pend_vld <= 1'b1;
      if (drop)               cmd_overflow <= 1'b1;

      if (state == ST_CAPTURE) begin
        rvalid <= 1'b1;
        rdata  <= (beat_resp == RESP_OKAY) ? mem_rd_data : '0;
        rresp  <= beat_resp;
      end else if (hs) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign rid     = act.id;
  assign rlast   = rvalid && last_beat;
  assign rd_busy = (state != ST_IDLE) || pend_vld;

endmodule

// File: doc/axi4_slave_read_data.md
# axi4_slave_read_data

AXI4 slave read-data (R) channel engine. Consumes the one-cycle command pulse and latched AR fields from the slave read-address stage. For each command it generates FIXED/INCR/WRAP beat addresses, reads a synchronous word memory, and returns `arlen+1` beats on the R channel with RID, RRESP and RLAST under RREADY backpressure. Sits directly downstream of the AR stage inside the AXI4 slave top.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, RDATA width; power of two, ≥ 8
- `ID_WIDTH`, 4, RID width
- `MEM_DEPTH`, 1024, memory depth in words; used only with the range check

Ports (reset `rst` is asynchronous, active-low; clock is `clk`):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-low reset
- `ar_transfer_occurred`  in  1  one-cycle command pulse; the `latched_*` fields are valid in the pulse cycle
- `latched_araddr`  in  ADDR_WIDTH  start byte address
- `latched_arid`  in  ID_WIDTH  transaction ID
- `latched_arlen`  in  8  beats minus 1
- `latched_arsize`  in  3  log2 of bytes per beat
- `latched_arburst`  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- `mem_rd_en`  out  1  memory read strobe
- `mem_rd_addr`  out  ADDR_WIDTH  word address, equal to byte address >> log2(DATA_WIDTH/8)
- `mem_rd_data`  in  DATA_WIDTH  read data, valid in the cycle after `mem_rd_en`
- `rvalid`  out  1  R beat valid
- `rready`  in  1  master ready
- `rdata`  out  DATA_WIDTH  read data (full word; no lane shifting)
- `rid`  out  ID_WIDTH  equals `latched_arid` of the active command
- `rresp`  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- `rlast`  out  1  high on the final beat
- `rd_busy`  out  1  high when a command is active or pending
- `cmd_overflow`  out  1  sticky flag; set when a command is dropped

## Operation
- FSM states: IDLE, FETCH, CAPTURE, DATA.
  - IDLE → FETCH on a command pulse.
  - FETCH drives `mem_rd_en`=1 and `mem_rd_addr`, then → CAPTURE.
  - CAPTURE registers `mem_rd_data` into `rdata`, sets `rvalid`, then → DATA.
  - DATA holds the beat until `rvalid && rready`.
    - On handshake with a non-last beat → FETCH.
    - On handshake with the last beat → FETCH if a command is pending, otherwise IDLE.
- Command capture: all five `latched_*` fields are copied into the active registers (from IDLE) or into a one-entry pending slot (when busy).
  - A pulse that coincides with the final handshake while the pending slot is empty loads directly into the active registers.
  - A pulse that arrives while the pending slot is full is dropped and sets `cmd_overflow`.
- Beat count: an 8-bit beat counter counts from 0 to `arlen`. `rlast` = (count == `arlen`).
- Address generation, with size = 1 << `arsize`:
  - FIXED: the address stays constant.
  - INCR: address += size; ADDR_WIDTH arithmetic, wraps modulo 2^ADDR_WIDTH.
  - WRAP: with total = size × (`arlen`+1) and lower = addr & ~(total−1), the next address is lower when addr+size == lower+total, otherwise addr+size.
- Error conditions. In every case the full `arlen`+1 beats are still returned with `rdata`=0 and RRESP = SLVERR (10), and FETCH issues no `mem_rd_en`:
  - `arburst` == 11;
  - WRAP with `arlen` ∉ {1,3,7,15};
  - size > DATA_WIDTH/8.
- `rvalid` never depends on `rready`. Once `rvalid` is asserted, `rdata`, `rresp`, `rid` and `rlast` stay stable until the handshake.

## Timing
- Reset values: every output is 0; the FSM is in IDLE; the pending slot is empty. Reset applied mid-burst abandons the burst immediately, and `rvalid` drops asynchronously.
- First-beat latency: pulse high in cycle P → FETCH in P+1 → CAPTURE in P+2 → `rvalid` high in P+3.
- Inter-beat: handshake in cycle k → next `rvalid` in k+3. Peak throughput is 1 beat per 3 cycles.
- `rd_busy` rises in P+1 and falls in the cycle after the last handshake when no command is pending.

## Configuration
- `AXI4_RD_ADDR_CHECK_EN`:
  - Defined: a beat whose word address ≥ MEM_DEPTH returns DECERR (11) with `rdata`=0 and no `mem_rd_en`. SLVERR takes priority over DECERR.
  - Undefined: no range check. The address is passed to memory unchanged and `MEM_DEPTH` is unused.

## Structure
- Package `axi4_pkg` holds:
  - the burst-type enum (FIXED/INCR/WRAP/RSVD);
  - the RRESP constants;
  - the read-data FSM state enum.
- One sub-module, `axi4_burst_addr_gen`: combinational next-address logic, with inputs addr, size, len and burst, and output next_addr.

## Test plan
1. INCR, `araddr`=0x100, `arsize`=2, `arlen`=3, `rready`=1 → `mem_rd_addr` 0x40, 0x41, 0x42, 0x43; four beats with OKAY; `rlast` only on beat 4; `rid` equals the command ID.
2. WRAP, `araddr`=0x108, `arsize`=2, `arlen`=3 → byte addresses 0x108, 0x10C, 0x100, 0x104.
3. FIXED, `araddr`=0x20, `arlen`=2 → three reads of word 0x8 and three beats.
4. `rready` held low for 5 cycles on beat 2 → `rvalid` and `rdata` held stable, no `mem_rd_en` during the stall; the burst then completes.
5. `arburst`=11, `arlen`=1 → two SLVERR beats, zero `mem_rd_en`. Separately, `arsize`=3 with DATA_WIDTH=32 → SLVERR.
6. Command B (ID 5) pulsed mid-burst of command A → B starts FETCH the cycle after A's `rlast` handshake, and `rid` switches to 5. A third pulse while B is pending sets `cmd_overflow`. Reset asserted mid-burst → all outputs 0 immediately.
